// File: rtl/plat_bank.sv
// Platform slot bank: spawns, scrolls and wraps NUM_PLAT platforms and answers
// landing queries by visiting one slot per clock.
//
//   state  | meaning
//   INIT   | spawn slot idx at Y = idx*SPACING, one slot per cycle
//   IDLE   | ready; services pending frame first, then pending query
//   SCROLL | add latched amount to slot idx, respawn on wrap
//   SCAN   | test slot idx against latched foot point; idx==NUM_PLAT reports
module plat_bank #(
    parameter int NUM_PLAT = 16,
    parameter int XW       = 9,
    parameter int YW       = 9,
    parameter int SCREEN_H = 480,
    parameter int SPACING  = 30,
    parameter int PLAY_W   = 480,
    parameter int PLAT_H   = 8,
    parameter int W_EASY   = 64,
    parameter int W_MED    = 48,
    parameter int W_HARD   = 32
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   frame_clk,
    input  logic [7:0]             scroll_amt,
    input  logic [1:0]             difficulty,
    input  logic                   land_req,
    input  logic [9:0]             land_x,
    input  logic [9:0]             land_y,
    output logic                   land_done,
    output logic                   land_hit,
    output logic [4:0]             land_idx,
    output logic [YW-1:0]          land_top,
    output logic [NUM_PLAT*XW-1:0] plat_x,
    output logic [NUM_PLAT*YW-1:0] plat_y,
    output logic [NUM_PLAT*7-1:0]  plat_w,
    output logic                   ready,
    output logic [11:0]            score,
    output logic                   overrun
);

    localparam int IW = $clog2(NUM_PLAT + 1);
    localparam int MW = (XW > YW) ? XW : YW;
    localparam int CW = ((MW > 10) ? MW : 10) + 2;
    localparam logic [15:0]   LFSR_SEED = 16'hACE1;
    localparam logic [15:0]   LFSR_MASK = 16'hB400;
    localparam logic [XW:0]   X_LIM     = (XW+1)'(PLAY_W - W_EASY);
    localparam logic [XW-1:0] X_OFF     = {1'b1, {(XW-1){1'b0}}};
    localparam logic [YW:0]   H_V       = (YW+1)'(SCREEN_H);

    typedef enum logic [1:0] {INIT, IDLE, SCROLL, SCAN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [7:0]      amt_q, amt_d;
    logic [11:0]     score_q, score_d;
    logic            ovr_q, ovr_d;
    logic            fpend_q, fpend_d;
    logic            lpend_q, lpend_d;
    logic [9:0]      px_q, px_d, py_q, py_d;
    logic [9:0]      sx_q, sx_d, sy_q, sy_d;
    logic            hit_q, hit_d;
    logic [4:0]      hidx_q, hidx_d;
    logic [YW-1:0]   htop_q, htop_d;
    logic            done_q, done_d;
    logic            rhit_q, rhit_d;
    logic [4:0]      ridx_q, ridx_d;
    logic [YW-1:0]   rtop_q, rtop_d;
    logic            frame_q;

    logic [XW-1:0]   x_q [NUM_PLAT];
    logic [YW-1:0]   y_q [NUM_PLAT];
    logic [6:0]      w_q [NUM_PLAT];

    logic [XW-1:0]   cur_x, wr_x, spawn_x, spawn_c;
    logic [YW-1:0]   cur_y, wr_y;
    logic [6:0]      cur_w, wr_w, spawn_w;
    logic            wr_en;
    logic [15:0]     lfsr_adv;
    logic [YW:0]     sum;
    logic            wrap, hit_now, frame_edge, last_slot;
    logic [11:0]     score_inc;

    always_comb begin
        cur_x = '0;
        cur_y = '0;
        cur_w = '0;
        for (int i = 0; i < NUM_PLAT; i++) begin
            if (idx_q == IW'(i)) begin
                cur_x = x_q[i];
                cur_y = y_q[i];
                cur_w = w_q[i];
            end
        end
    end

    assign frame_edge = frame_clk & ~frame_q;
    assign last_slot  = (idx_q == IW'(NUM_PLAT - 1));
    assign lfsr_adv   = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    assign spawn_c    = lfsr_q[XW-1:0];
    // Candidates past the right edge fold back by half the X range.
    assign spawn_x    = ({1'b0, spawn_c} >= X_LIM) ? (spawn_c - X_OFF) : spawn_c;
    assign spawn_w    = (difficulty == 2'd0) ? 7'(W_EASY) :
                        (difficulty == 2'd1) ? 7'(W_MED)  : 7'(W_HARD);
    assign sum        = {1'b0, cur_y} + (YW+1)'(amt_q);
    assign wrap       = (sum >= H_V);
    assign score_inc  = (score_q == 12'hFFF) ? score_q : score_q + 12'd1;
    assign hit_now    = (CW'(cur_y) <= CW'(sy_q)) &&
                        (CW'(sy_q) < CW'(cur_y) + CW'(PLAT_H)) &&
                        (CW'(cur_x) <= CW'(sx_q)) &&
                        (CW'(sx_q) < CW'(cur_x) + CW'(cur_w));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lfsr_d  = lfsr_q;
        amt_d   = amt_q;
        score_d = score_q;
        ovr_d   = ovr_q;
        fpend_d = fpend_q;
        lpend_d = lpend_q;
        px_d    = px_q;
        py_d    = py_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        hit_d   = hit_q;
        hidx_d  = hidx_q;
        htop_d  = htop_q;
        done_d  = 1'b0;
        rhit_d  = rhit_q;
        ridx_d  = ridx_q;
        rtop_d  = rtop_q;
        wr_en   = 1'b0;
        wr_x    = cur_x;
        wr_y    = cur_y;
        wr_w    = cur_w;

        // The newest request always owns the pending coordinates.
        if (land_req) begin
            px_d = land_x;
            py_d = land_y;
        end
        if (state_q != IDLE) begin
            if (frame_edge) begin
                if (fpend_q) ovr_d = 1'b1;
                else         fpend_d = 1'b1;
            end
            if (land_req) lpend_d = 1'b1;
        end

        case (state_q)
            INIT: begin
                wr_en  = 1'b1;
                wr_x   = spawn_x;
                wr_y   = YW'(32'(idx_q) * 32'(SPACING));
                wr_w   = spawn_w;
                lfsr_d = lfsr_adv;
                if (last_slot) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            IDLE: begin
                if ((frame_edge || fpend_q) && (scroll_amt != 8'd0)) begin
                    state_d = SCROLL;
                    idx_d   = '0;
                    amt_d   = scroll_amt;
                    fpend_d = 1'b0;
                    if (land_req) lpend_d = 1'b1;
                end else begin
                    fpend_d = 1'b0;
                    if (land_req || lpend_q) begin
                        state_d = SCAN;
                        idx_d   = '0;
                        lpend_d = 1'b0;
                        sx_d    = land_req ? land_x : px_q;
                        sy_d    = land_req ? land_y : py_q;
                        hit_d   = 1'b0;
                        hidx_d  = '0;
                        htop_d  = '0;
                    end
                end
            end
            SCROLL: begin
                wr_en = 1'b1;
                if (wrap) begin
                    wr_y    = YW'(sum - H_V);
                    wr_x    = spawn_x;
                    wr_w    = spawn_w;
                    lfsr_d  = lfsr_adv;
                    score_d = score_inc;
                end else begin
                    wr_y = sum[YW-1:0];
                end
                if (last_slot) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            SCAN: begin
                if (idx_q == IW'(NUM_PLAT)) begin
                    done_d  = 1'b1;
                    rhit_d  = hit_q;
                    ridx_d  = hidx_q;
                    rtop_d  = htop_q;
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    if (hit_now && !hit_q) begin
                        hit_d  = 1'b1;
                        hidx_d = 5'(idx_q);
                        htop_d = cur_y;
                    end
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        frame_q <= frame_clk;
        if (!Reset_n) begin
            state_q <= INIT;
            idx_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            amt_q   <= '0;
            score_q <= '0;
            ovr_q   <= 1'b0;
            fpend_q <= 1'b0;
            lpend_q <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            hit_q   <= 1'b0;
            hidx_q  <= '0;
            htop_q  <= '0;
            done_q  <= 1'b0;
            rhit_q  <= 1'b0;
            ridx_q  <= '0;
            rtop_q  <= '0;
            for (int i = 0; i < NUM_PLAT; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_d;
            amt_q   <= amt_d;
            score_q <= score_d;
            ovr_q   <= ovr_d;
            fpend_q <= fpend_d;
            lpend_q <= lpend_d;
            px_q    <= px_d;
            py_q    <= py_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            hit_q   <= hit_d;
            hidx_q  <= hidx_d;
            htop_q  <= htop_d;
            done_q  <= done_d;
            rhit_q  <= rhit_d;
            ridx_q  <= ridx_d;
            rtop_q  <= rtop_d;
            for (int i = 0; i < NUM_PLAT; i++) begin
                if (wr_en && (idx_q == IW'(i))) begin
                    x_q[i] <= wr_x;
                    y_q[i] <= wr_y;
                    w_q[i] <= wr_w;
                end
            end
        end
    end

    always_comb begin
        plat_x = '0;
        plat_y = '0;
        plat_w = '0;
        for (int i = 0; i < NUM_PLAT; i++) begin
            plat_x[i*XW +: XW] = x_q[i];
            plat_y[i*YW +: YW] = y_q[i];
            plat_w[i*7 +: 7]   = w_q[i];
        end
    end

    assign ready     = (state_q == IDLE);
    assign score     = score_q;
    assign overrun   = ovr_q;
    assign land_done = done_q;
    assign land_hit  = rhit_q;
    assign land_idx  = ridx_q;
    assign land_top  = rtop_q;

endmodule

// File: tb/tb_plat_bank.sv
// Randomized self-checking bench for plat_bank against a slot-list model.
module tb_plat_bank;
    localparam int NP = 16;
    localparam int XW = 9;
    localparam int YW = 9;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic frame_clk = 1'b0;
    logic land_req = 1'b0;
    logic [7:0] scroll_amt = 8'd0;
    logic [1:0] difficulty = 2'd0;
    logic [9:0] land_x = 10'd0;
    logic [9:0] land_y = 10'd0;
    logic land_done, land_hit, ready, overrun;
    logic [4:0] land_idx;
    logic [YW-1:0] land_top;
    logic [NP*XW-1:0] plat_x;
    logic [NP*YW-1:0] plat_y;
    logic [NP*7-1:0] plat_w;
    logic [11:0] score;

    int n_checks = 0;
    int n_pass = 0;
    int mx[NP];
    int my[NP];
    int mw[NP];
    int m_lfsr;
    int m_score;
    logic [NP*XW-1:0] init_xv;

    always #5 Clk = ~Clk;

    plat_bank dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .scroll_amt(scroll_amt), .difficulty(difficulty),
        .land_req(land_req), .land_x(land_x), .land_y(land_y),
        .land_done(land_done), .land_hit(land_hit), .land_idx(land_idx),
        .land_top(land_top), .plat_x(plat_x), .plat_y(plat_y),
        .plat_w(plat_w), .ready(ready), .score(score), .overrun(overrun)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int spawn_x();
        int c;
        c = m_lfsr & 511;
        m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
        return (c >= 416) ? c - 256 : c;
    endfunction

    function automatic int width_of(input int d);
        return (d == 0) ? 64 : (d == 1) ? 48 : 32;
    endfunction

    function automatic void model_init(input int d);
        m_lfsr = 'hACE1;
        m_score = 0;
        for (int i = 0; i < NP; i++) begin
            my[i] = i * 30;
            mx[i] = spawn_x();
            mw[i] = width_of(d);
        end
    endfunction

    function automatic void model_scroll(input int amt, input int d);
        for (int i = 0; i < NP; i++) begin
            if (my[i] + amt >= 480) begin
                my[i] = my[i] + amt - 480;
                mx[i] = spawn_x();
                mw[i] = width_of(d);
                if (m_score < 4095) m_score++;
            end else begin
                my[i] = my[i] + amt;
            end
        end
    endfunction

    function automatic void model_query(input int lx, input int ly,
                                        output logic hit, output int idx, output int top);
        hit = 1'b0; idx = 0; top = 0;
        for (int i = 0; i < NP; i++) begin
            if (!hit && my[i] <= ly && ly < my[i] + 8 && mx[i] <= lx && lx < mx[i] + mw[i]) begin
                hit = 1'b1; idx = i; top = my[i];
            end
        end
    endfunction

    function automatic logic [NP*XW-1:0] exp_x();
        logic [NP*XW-1:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) r[i*XW +: XW] = XW'(mx[i]);
        return r;
    endfunction

    function automatic logic [NP*YW-1:0] exp_y();
        logic [NP*YW-1:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) r[i*YW +: YW] = YW'(my[i]);
        return r;
    endfunction

    function automatic logic [NP*7-1:0] exp_w();
        logic [NP*7-1:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) r[i*7 +: 7] = 7'(mw[i]);
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic run_scroll(input int amt, output int n);
        scroll_amt = 8'(amt);
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic run_query(input int lx, input int ly, output int n);
        land_x = 10'(lx);
        land_y = 10'(ly);
        land_req = 1'b1;
        tick();
        land_req = 1'b0;
        n = 0;
        while (!land_done && n < 200) begin
            tick();
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset_n = 1'b0;
        difficulty = 2'd0;
        repeat (3) tick();
        n_checks++; if (ready !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", ready); else n_pass++;
        n_checks++; if (score !== 12'd0) $display("FAIL reset_score got=%0d exp=0", score); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%0b exp=0", overrun); else n_pass++;
        n_checks++; if ({land_done, land_hit, land_idx, land_top} !== '0)
            $display("FAIL reset_land got=%0b/%0b/%0d/%0d exp=0", land_done, land_hit, land_idx, land_top); else n_pass++;
        n_checks++; if ({plat_x, plat_y, plat_w} !== '0) $display("FAIL reset_slots got=nonzero exp=0"); else n_pass++;
    endtask

    task automatic test_init();
        int n;
        logic all_lt;
        Reset_n = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        model_init(0);
        init_xv = exp_x();
        n_checks++; if (n != 16) $display("FAIL init_latency got=%0d exp=16", n); else n_pass++;
        n_checks++; if (plat_y[5*YW +: YW] !== 9'd150) $display("FAIL init_y5 got=%0d exp=150", plat_y[5*YW +: YW]); else n_pass++;
        n_checks++; if (plat_x !== exp_x()) $display("FAIL init_x got=%h exp=%h", plat_x, exp_x()); else n_pass++;
        n_checks++; if (plat_y !== exp_y()) $display("FAIL init_y got=%h exp=%h", plat_y, exp_y()); else n_pass++;
        n_checks++; if (plat_w !== exp_w()) $display("FAIL init_w got=%h exp=%h", plat_w, exp_w()); else n_pass++;
        all_lt = 1'b1;
        for (int i = 0; i < NP; i++) if (plat_x[i*XW +: XW] >= 9'd416) all_lt = 1'b0;
        n_checks++; if (all_lt !== 1'b1) $display("FAIL init_x_range got=some_x>=416 exp=all<416"); else n_pass++;
    endtask

    task automatic test_scroll40();
        int n;
        run_scroll(40, n);
        model_scroll(40, 0);
        n_checks++; if (n != 16) $display("FAIL s40_busy got=%0d exp=16", n); else n_pass++;
        n_checks++; if (plat_y[0 +: YW] !== 9'd40) $display("FAIL s40_y0 got=%0d exp=40", plat_y[0 +: YW]); else n_pass++;
        n_checks++; if (plat_y[15*YW +: YW] !== 9'd10) $display("FAIL s40_y15 got=%0d exp=10", plat_y[15*YW +: YW]); else n_pass++;
        n_checks++; if (plat_x !== exp_x()) $display("FAIL s40_x got=%h exp=%h", plat_x, exp_x()); else n_pass++;
        n_checks++; if (score !== 12'd1) $display("FAIL s40_score got=%0d exp=1", score); else n_pass++;
    endtask

    task automatic test_random_scroll();
        int n, amt, d;
        for (int k = 0; k < 6; k++) begin
            amt = $urandom_range(1, 255);
            d = $urandom_range(0, 3);
            difficulty = 2'(d);
            run_scroll(amt, n);
            model_scroll(amt, d);
            n_checks++; if (n != 16) $display("FAIL rs%0d_busy got=%0d exp=16", k, n); else n_pass++;
            n_checks++; if ({plat_x, plat_y, plat_w} !== {exp_x(), exp_y(), exp_w()})
                $display("FAIL rs%0d_slots amt=%0d got=%h/%h exp=%h/%h", k, amt, plat_x, plat_y, exp_x(), exp_y()); else n_pass++;
            n_checks++; if (score !== 12'(m_score)) $display("FAIL rs%0d_score got=%0d exp=%0d", k, score, m_score); else n_pass++;
        end
        n_checks++; if (overrun !== 1'b0) $display("FAIL rs_overrun got=%0b exp=0", overrun); else n_pass++;
    endtask

    task automatic test_zero_scroll();
        logic stayed;
        scroll_amt = 8'd0;
        frame_clk = 1'b1;
        tick();
        stayed = ready;
        frame_clk = 1'b0;
        repeat (3) begin
            tick();
            stayed = stayed & ready;
        end
        n_checks++; if (stayed !== 1'b1) $display("FAIL zero_ready got=dropped exp=held"); else n_pass++;
        n_checks++; if (plat_y !== exp_y()) $display("FAIL zero_y got=%h exp=%h", plat_y, exp_y()); else n_pass++;
    endtask

    task automatic test_hard_wrap();
        int n, prev_score;
        logic [NP*YW-1:0] prev_y;
        logic [NP*7-1:0] all32;
        prev_y = exp_y();
        prev_score = m_score;
        all32 = '0;
        for (int i = 0; i < NP; i++) all32[i*7 +: 7] = 7'd32;
        difficulty = 2'd2;
        run_scroll(240, n);
        model_scroll(240, 2);
        run_scroll(240, n);
        model_scroll(240, 2);
        n_checks++; if (plat_y !== prev_y) $display("FAIL hard_y got=%h exp=%h", plat_y, prev_y); else n_pass++;
        n_checks++; if (plat_w !== all32) $display("FAIL hard_w got=%h exp=%h", plat_w, all32); else n_pass++;
        n_checks++; if (score !== 12'(prev_score + 16)) $display("FAIL hard_score got=%0d exp=%0d", score, prev_score + 16); else n_pass++;
        n_checks++; if (plat_x !== exp_x()) $display("FAIL hard_x got=%h exp=%h", plat_x, exp_x()); else n_pass++;
    endtask

    task automatic test_query();
        int n, eidx, etop, lx, ly, k;
        logic ehit;
        int qx[4];
        int qy[4];
        qx[0] = mx[3];             qy[0] = my[3] + 2;
        qx[1] = mx[3] + mw[3];     qy[1] = my[3] + 2;
        qx[2] = mx[3] + mw[3] - 1; qy[2] = my[3] + 7;
        qx[3] = mx[3];             qy[3] = my[3] + 8;
        for (int q = 0; q < 12; q++) begin
            if (q < 4) begin
                lx = qx[q]; ly = qy[q];
            end else if (q % 4 == 0) begin
                lx = $urandom_range(0, 1023); ly = $urandom_range(0, 1023);
            end else begin
                k = $urandom_range(0, NP - 1);
                lx = mx[k] + $urandom_range(0, mw[k]);
                ly = my[k] + $urandom_range(0, 9);
            end
            model_query(lx, ly, ehit, eidx, etop);
            run_query(lx, ly, n);
            n_checks++; if (n != 17) $display("FAIL q%0d_latency got=%0d exp=17", q, n); else n_pass++;
            n_checks++; if ({land_hit, land_idx, land_top} !== {ehit, 5'(eidx), YW'(etop)})
                $display("FAIL q%0d_result x=%0d y=%0d got=%0b/%0d/%0d exp=%0b/%0d/%0d",
                         q, lx, ly, land_hit, land_idx, land_top, ehit, eidx, etop); else n_pass++;
            tick();
            n_checks++; if ({land_done, land_hit, land_idx} !== {1'b0, ehit, 5'(eidx)})
                $display("FAIL q%0d_hold got=%0b/%0b/%0d exp=0/%0b/%0d", q, land_done, land_hit, land_idx, ehit, eidx); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int n, amt, d, k, lx, ly, eidx, etop;
        logic ehit;
        amt = $urandom_range(1, 255);
        d = $urandom_range(0, 3);
        difficulty = 2'(d);
        model_scroll(amt, d);
        model_scroll(amt, d);
        k = $urandom_range(0, NP - 1);
        lx = mx[k] + 1;
        ly = my[k] + 3;
        model_query(lx, ly, ehit, eidx, etop);
        scroll_amt = 8'(amt);
        land_x = 10'(lx);
        land_y = 10'(ly);
        frame_clk = 1'b1;
        land_req = 1'b1;
        tick();
        frame_clk = 1'b0;
        land_req = 1'b0;
        n = 0;
        while (!land_done && n < 300) begin
            frame_clk = (n == 1 || n == 3);
            tick();
            n++;
        end
        frame_clk = 1'b0;
        n_checks++; if (n != 51) $display("FAIL b2b_latency got=%0d exp=51", n); else n_pass++;
        n_checks++; if ({land_hit, land_idx, land_top} !== {ehit, 5'(eidx), YW'(etop)})
            $display("FAIL b2b_result got=%0b/%0d/%0d exp=%0b/%0d/%0d", land_hit, land_idx, land_top, ehit, eidx, etop); else n_pass++;
        n_checks++; if (overrun !== 1'b1) $display("FAIL b2b_overrun got=%0b exp=1", overrun); else n_pass++;
        n_checks++; if (score !== 12'(m_score)) $display("FAIL b2b_score got=%0d exp=%0d", score, m_score); else n_pass++;
        n_checks++; if ({plat_x, plat_y} !== {exp_x(), exp_y()}) $display("FAIL b2b_slots got=%h exp=%h", plat_y, exp_y()); else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        int n;
        logic saw_done;
        difficulty = 2'd0;
        land_x = 10'(mx[0]);
        land_y = 10'(my[0]);
        land_req = 1'b1;
        tick();
        land_req = 1'b0;
        repeat (5) tick();
        Reset_n = 1'b0;
        tick();
        saw_done = land_done;
        n_checks++; if (score !== 12'd0) $display("FAIL rst_score got=%0d exp=0", score); else n_pass++;
        n_checks++; if ({overrun, ready, land_hit} !== 3'b000)
            $display("FAIL rst_flags got=%0b/%0b/%0b exp=0/0/0", overrun, ready, land_hit); else n_pass++;
        Reset_n = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
            saw_done = saw_done | land_done;
        end
        repeat (20) begin
            tick();
            saw_done = saw_done | land_done;
        end
        model_init(0);
        n_checks++; if (n != 16) $display("FAIL rst_init_latency got=%0d exp=16", n); else n_pass++;
        n_checks++; if (saw_done !== 1'b0) $display("FAIL rst_no_done got=%0b exp=0", saw_done); else n_pass++;
        n_checks++; if (plat_x !== init_xv) $display("FAIL rst_x got=%h exp=%h", plat_x, init_xv); else n_pass++;
        n_checks++; if ({plat_y, plat_w} !== {exp_y(), exp_w()}) $display("FAIL rst_yw got=%h exp=%h", plat_y, exp_y()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_init();
        test_scroll40();
        test_random_scroll();
        test_zero_scroll();
        test_hard_wrap();
        test_query();
        test_back_to_back();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
